// File: rtl/washer_plant_model.sv
// washer_plant_model: behavioural model of the washer appliance (door,
// water level, detergent dispenser, drum timers). It takes the washer
// controller's actuator commands and returns its sensor feedback.
// Build option: define PLANT_FAULT_CHECK_EN to include the sticky protocol
// fault checker. Without it, fault is tied low.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | motor off; drum timer and both timeouts held clear
//   S_WASH | motor on, drain closed; timer runs while drum is full
//   S_SPIN | motor on, drain open; timer runs while drum is empty
module washer_plant_model #(
   parameter int FILL_CYCLES  = 8,
   parameter int DRAIN_CYCLES = 6,
   parameter int DET_CYCLES   = 3,
   parameter int WASH_CYCLES  = 10,
   parameter int SPIN_CYCLES  = 5,
   parameter int CNT_W        = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic door_req,
   input  logic door_lock,
   input  logic fill_value_on,
   input  logic drain_value_on,
   input  logic motor_on,
   input  logic soap_wash,
   input  logic water_wash,
   input  logic done,
   output logic door_close,
   output logic filled,
   output logic drained,
   output logic detergent_added,
   output logic cycle_timeout,
   output logic spin_timeout,
   output logic fault
);

   // Every cycle count must be non-zero and fit in a CNT_W-bit counter.
   // Draining always moves the level one unit per cycle, so DRAIN_CYCLES
   // only has to be a legal count.
   generate
      if (FILL_CYCLES < 1 || DRAIN_CYCLES < 1 || DET_CYCLES < 1 ||
          WASH_CYCLES < 1 || SPIN_CYCLES < 1 ||
          (FILL_CYCLES >> CNT_W) != 0 || (DRAIN_CYCLES >> CNT_W) != 0 ||
          (DET_CYCLES >> CNT_W) != 0 || (WASH_CYCLES >> CNT_W) != 0 ||
          (SPIN_CYCLES >> CNT_W) != 0) begin : g_param_err
         $error("washer_plant_model: cycle parameter out of range");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WASH = 2'd1,
      S_SPIN = 2'd2
   } drum_state_t;

   localparam logic [CNT_W-1:0] LEVEL_FULL = CNT_W'(FILL_CYCLES);
   localparam logic [CNT_W-1:0] DET_LAST   = CNT_W'(DET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYCLES - 1);
   localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   logic             door_close_q, door_close_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
   logic             det_added_q, det_added_d;
   drum_state_t      state_q, state_d;
   logic [CNT_W-1:0] drum_cnt_q, drum_cnt_d;
   logic             cyc_to_q, cyc_to_d;
   logic             spin_to_q, spin_to_d;
   logic             filled_w, drained_w;

   assign filled_w  = (level_q == LEVEL_FULL);
   assign drained_w = (level_q == '0);

   // Door follows the user's request unless the controller holds the lock.
   always_comb begin
      door_close_d = door_lock ? door_close_q : door_req;
   end

   // Water level: fill-only raises it, drain-only lowers it, both or neither hold.
   always_comb begin
      level_d = level_q;
      if (fill_value_on && !drain_value_on) begin
         if (level_q != LEVEL_FULL) level_d = level_q + ONE;
      end else if (drain_value_on && !fill_value_on) begin
         if (level_q != '0) level_d = level_q - ONE;
      end
   end

   // Detergent dispenser. done takes priority over a threshold hit on the same edge.
   always_comb begin
      det_cnt_d   = det_cnt_q;
      det_added_d = det_added_q;
      if (done) begin
         det_cnt_d   = '0;
         det_added_d = 1'b0;
      end else if (soap_wash && filled_w && !det_added_q) begin
         if (det_cnt_q == DET_LAST) begin
            det_cnt_d   = '0;
            det_added_d = 1'b1;
         end else begin
            det_cnt_d = det_cnt_q + ONE;
         end
      end
   end

   // Drum FSM next state and drum timer. A state change restarts the timer.
   always_comb begin
      state_d    = state_q;
      drum_cnt_d = drum_cnt_q;
      cyc_to_d   = cyc_to_q;
      spin_to_d  = spin_to_q;
      case (state_q)
         S_IDLE: if (motor_on) state_d = drain_value_on ? S_SPIN : S_WASH;
         S_WASH: begin
            if (!motor_on)          state_d = S_IDLE;
            else if (drain_value_on) state_d = S_SPIN;
         end
         S_SPIN: begin
            if (!motor_on)           state_d = S_IDLE;
            else if (!drain_value_on) state_d = S_WASH;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q || state_q == S_IDLE) begin
         drum_cnt_d = '0;
         cyc_to_d   = 1'b0;
         spin_to_d  = 1'b0;
      end else if (state_q == S_WASH) begin
         if (filled_w && !cyc_to_q) begin
            drum_cnt_d = drum_cnt_q + ONE;
            if (drum_cnt_q == WASH_LAST) cyc_to_d = 1'b1;
         end
      end else if (state_q == S_SPIN) begin
         if (drained_w && !spin_to_q) begin
            drum_cnt_d = drum_cnt_q + ONE;
            if (drum_cnt_q == SPIN_LAST) spin_to_d = 1'b1;
         end
      end
   end

   // Plant state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         door_close_q <= 1'b0;
         level_q      <= '0;
         det_cnt_q    <= '0;
         det_added_q  <= 1'b0;
         state_q      <= S_IDLE;
         drum_cnt_q   <= '0;
         cyc_to_q     <= 1'b0;
         spin_to_q    <= 1'b0;
      end else begin
         door_close_q <= door_close_d;
         level_q      <= level_d;
         det_cnt_q    <= det_cnt_d;
         det_added_q  <= det_added_d;
         state_q      <= state_d;
         drum_cnt_q   <= drum_cnt_d;
         cyc_to_q     <= cyc_to_d;
         spin_to_q    <= spin_to_d;
      end
   end

`ifdef PLANT_FAULT_CHECK_EN
   logic fault_q, fault_d;
   logic door_lock_q;

   // Latch any illegal command combination; only reset clears it.
   always_comb begin
      fault_d = fault_q;
      if ((fill_value_on && drain_value_on) ||
          (motor_on && !door_close_q) ||
          (soap_wash && water_wash) ||
          (door_lock && !door_lock_q && !door_close_q)) begin
         fault_d = 1'b1;
      end
   end

   // Fault flag and previous lock command for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q     <= 1'b0;
         door_lock_q <= 1'b0;
      end else begin
         fault_q     <= fault_d;
         door_lock_q <= door_lock;
      end
   end

   assign fault = fault_q;
`else
   logic unused_fault_inputs;
   assign unused_fault_inputs = water_wash;
   assign fault = 1'b0;
`endif

   assign door_close      = door_close_q;
   assign filled          = filled_w;
   assign drained         = drained_w;
   assign detergent_added = det_added_q;
   assign cycle_timeout   = cyc_to_q;
   assign spin_timeout    = spin_to_q;

endmodule
